// File: rtl/cacheline_arbiter_if.sv
// Cache-side and adaptor-side buses of the cacheline arbiter.
// slave is the arbiter's view; master is the view of the caches plus adaptor.
interface cacheline_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between icache and dcache, one whole line
// at a time, alternating priority on contention so neither side starves.
//
// state   | meaning
// IDLE    | no transaction; arbitrate pending requests
// SERVE_I | icache read outstanding at the adaptor
// SERVE_D | dcache read or writeback outstanding at the adaptor
// RESP    | one-cycle completion pulse to the served cache
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic                clk,
  input logic                rst,
  cacheline_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic ICACHE = 1'b0;
  localparam logic DCACHE = 1'b1;

  logic [1:0]        state;
  logic              last_grant;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic [LINE_W-1:0] d_rdata;
  logic              i_resp;
  logic              d_resp;

  logic i_pend;
  logic d_pend;
  logic grant_d;

  always_comb begin
    i_pend  = bus.i_read;
    d_pend  = bus.d_read | bus.d_write;
    // on a tie the side that was not served last wins
    grant_d = d_pend & (~i_pend | (last_grant == ICACHE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            pmem_addr  <= bus.d_addr;
            last_grant <= DCACHE;
            state      <= SERVE_D;
            // a simultaneous read+write is treated as a writeback
            if (bus.d_write) begin
              pmem_write <= 1'b1;
              pmem_wdata <= bus.d_wdata;
            end else begin
              pmem_read  <= 1'b1;
            end
          end else if (i_pend) begin
            pmem_addr  <= bus.i_addr;
            pmem_read  <= 1'b1;
            last_grant <= ICACHE;
            state      <= SERVE_I;
          end
        end
        SERVE_I: begin
          if (bus.pmem_resp) begin
            pmem_read <= 1'b0;
            i_rdata   <= bus.pmem_rdata;
            i_resp    <= 1'b1;
            state     <= RESP;
          end
        end
        SERVE_D: begin
          if (bus.pmem_resp) begin
            if (pmem_read) begin
              d_rdata <= bus.pmem_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            d_resp     <= 1'b1;
            state      <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;
  assign bus.pmem_addr  = pmem_addr;
  assign bus.pmem_wdata = pmem_wdata;
  assign bus.i_rdata    = i_rdata;
  assign bus.d_rdata    = d_rdata;
  assign bus.i_resp     = i_resp;
  assign bus.d_resp     = d_resp;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// Bench for cacheline_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cacheline_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] wdata;
    int            lat;
    logic [LW-1:0] mdata;
    logic          exp_d;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[6];
  int   total  = 0;
  int   passed = 0;

  // transaction-level model: last served side and each cache's returned line
  logic          last_d;
  logic [LW-1:0] i_m;
  logic [LW-1:0] d_m;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b0;
    i_m = '0;
    d_m = '0;
  endtask

  // called just after the grant edge; completes the transaction through RESP
  task automatic serve(input logic ed, input logic ew, input logic [AW-1:0] ea,
                       input logic [LW-1:0] ewd, input int lat,
                       input logic [LW-1:0] rd, input logic scr);
    check("grant_read", bus.pmem_read, !ew);
    check("grant_write", bus.pmem_write, ew);
    check("grant_addr", bus.pmem_addr, ea);
    if (ew) check("grant_wdata", bus.pmem_wdata, ewd);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (scr) begin
        if (ed) begin
          bus.d_addr  = bus.d_addr ^ 32'h0001_0000;
          bus.d_wdata = rand_line();
        end else begin
          bus.i_addr = bus.i_addr ^ 32'h0000_0100;
        end
      end
      check("hold_addr", bus.pmem_addr, ea);
      check("hold_op", {bus.pmem_read, bus.pmem_write}, {!ew, ew});
      if (ew) check("hold_wdata", bus.pmem_wdata, ewd);
      check("no_early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    end
    bus.pmem_rdata = rd;
    bus.pmem_resp  = 1'b1;
    @(posedge clk); #1;
    if (!ew) begin
      if (ed) d_m = rd;
      else    i_m = rd;
    end
    check("i_resp", bus.i_resp, !ed);
    check("d_resp", bus.d_resp, ed);
    check("i_rdata", bus.i_rdata, i_m);
    check("d_rdata", bus.d_rdata, d_m);
    check("pmem_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
    last_d = ed;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = rand_line();
    if (ed) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    else    bus.i_read = 1'b0;
    @(posedge clk); #1;
    check("resp_one_cycle", {bus.i_resp, bus.d_resp}, 2'b00);
    check("idle_gap", {bus.pmem_read, bus.pmem_write}, 2'b00);
  endtask

  // one arbitration round: raise requests in the idle cycle, predict the winner
  task automatic round(input bit want_i, input bit want_d, input bit want_w, input bit scr);
    logic          ed, ew;
    logic [AW-1:0] ea;
    @(negedge clk);
    if (want_i && !bus.i_read) begin
      bus.i_read = 1'b1;
      bus.i_addr = $urandom() & 32'hFFFF_FFE0;
    end
    if (want_d && !(bus.d_read || bus.d_write)) begin
      bus.d_write = want_w;
      bus.d_read  = !want_w;
      bus.d_addr  = $urandom() & 32'hFFFF_FFE0;
      bus.d_wdata = rand_line();
    end
    if (!bus.i_read && !bus.d_read && !bus.d_write) begin
      @(posedge clk); #1;
      check("idle_no_req", {bus.pmem_read, bus.pmem_write}, 2'b00);
      return;
    end
    ed = (bus.d_read || bus.d_write) && (!bus.i_read || !last_d);
    ew = ed && bus.d_write;
    ea = ed ? bus.d_addr : bus.i_addr;
    @(posedge clk); #1;
    serve(ed, ew, ea, bus.d_wdata, $urandom_range(1, 4), rand_line(), scr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h60,  32'h0,   '0,                 3, {32{8'hA5}},        1'b0, 1'b0, 32'h60};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h200, '0,                 1, {8{32'h0123_4567}}, 1'b1, 1'b0, 32'h200};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,   32'h340, {8{32'hDEADBEEF}},  2, {8{32'h5555_AAAA}}, 1'b1, 1'b1, 32'h340};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h200, '0,                 2, {8{32'hCAFE_F00D}}, 1'b1, 1'b0, 32'h200};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h480, {8{32'h1357_9BDF}}, 1, {8{32'h0F0F_0F0F}}, 1'b1, 1'b1, 32'h480};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h140, 32'h500, {8{32'h2468_ACE0}}, 4, {8{32'h7777_8888}}, 1'b1, 1'b1, 32'h500};

    do_reset();
    #1;
    check("rst_pmem_read", bus.pmem_read, 1'b0);
    check("rst_pmem_write", bus.pmem_write, 1'b0);
    check("rst_pmem_addr", bus.pmem_addr, '0);
    check("rst_pmem_wdata", bus.pmem_wdata, '0);
    check("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    check("rst_i_rdata", bus.i_rdata, '0);
    check("rst_d_rdata", bus.d_rdata, '0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.i_read  = vecs[v].i_rd;
      bus.i_addr  = vecs[v].i_addr;
      bus.d_read  = vecs[v].d_rd;
      bus.d_write = vecs[v].d_wr;
      bus.d_addr  = vecs[v].d_addr;
      bus.d_wdata = vecs[v].wdata;
      @(posedge clk); #1;
      serve(vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].wdata,
            vecs[v].lat, vecs[v].mdata, 1'b1);
    end

    // reset in the middle of a writeback, then a stray pmem_resp in IDLE
    do_reset();
    bus.d_write = 1'b1; bus.d_addr = 32'h340; bus.d_wdata = {8{32'hDEADBEEF}};
    @(posedge clk); #1;
    check("mid_rst_write_up", bus.pmem_write, 1'b1);
    @(negedge clk);
    rst = 1'b1; bus.d_write = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_write_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
    check("mid_rst_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(negedge clk);
    rst = 1'b0; last_d = 1'b0; i_m = '0; d_m = '0;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = {8{32'hBAD0_BAD0}};
    @(posedge clk); #1;
    check("stray_resp_ignored", {bus.i_resp, bus.d_resp}, 2'b00);
    check("stray_rdata_ignored", bus.d_rdata, '0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    @(posedge clk); #1;
    check("stray_no_late_resp", {bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}, 4'b0000);
    @(negedge clk);
    bus.i_read = 1'b1; bus.i_addr = 32'h60;
    @(posedge clk); #1;
    serve(1'b0, 1'b0, 32'h60, '0, 1, {32{8'h3C}}, 1'b0);

    // continuous contention: grants must alternate D,I,D,I,D,I
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!bus.i_read) begin bus.i_read = 1'b1; bus.i_addr = 32'h100; end
      if (!bus.d_read) begin bus.d_read = 1'b1; bus.d_addr = 32'h200; end
      @(posedge clk); #1;
      serve(k % 2 == 0, 1'b0, (k % 2 == 0) ? 32'h200 : 32'h100, '0,
            1 + k % 3, rand_line(), 1'b0);
    end

    for (int n = 0; n < 60; n++) begin
      round($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares one physical cacheline memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two caches and the cacheline adaptor that drives the burst memory port (mem_read/mem_write/mem_addr/mem_rdata/mem_wdata/mem_resp).
- Serves one whole-line transaction at a time.
- Uses alternating-priority arbitration so neither cache can starve the other.

Parameters:
- ADDR_W, 32, byte address width of every port.
- LINE_W, 256, cacheline width in bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_read  input  1  icache line read request; held until i_resp
- i_addr  input  ADDR_W  icache line address (low 5 bits zero)
- i_rdata  output  LINE_W  line returned to icache; valid when i_resp=1
- i_resp  output  1  one-cycle completion pulse to icache
- d_read  input  1  dcache line read request; held until d_resp
- d_write  input  1  dcache line writeback request; held until d_resp
- d_addr  input  ADDR_W  dcache line address
- d_wdata  input  LINE_W  dcache writeback line
- d_rdata  output  LINE_W  line returned to dcache; valid when d_resp=1
- d_resp  output  1  one-cycle completion pulse to dcache
- pmem_read  output  1  read request to cacheline adaptor
- pmem_write  output  1  write request to cacheline adaptor
- pmem_addr  output  ADDR_W  line address to adaptor
- pmem_wdata  output  LINE_W  write line to adaptor
- pmem_rdata  input  LINE_W  read line from adaptor; valid with pmem_resp
- pmem_resp  input  1  one-cycle completion pulse from adaptor

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high. All outputs are registered.
- Reset:
  - state=IDLE, last_grant=ICACHE.
  - All outputs are 0: pmem_read, pmem_write, pmem_addr, pmem_wdata, i_resp, d_resp, i_rdata, d_rdata.
- Reset mid-transaction: the downstream request is dropped the next cycle. No resp is issued, and a pmem_resp arriving afterwards is ignored in IDLE.
- States: IDLE, SERVE_I, SERVE_D, RESP.
- IDLE:
  - d_pend = d_read|d_write; i_pend = i_read.
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant. The first tie after reset goes to dcache.
  - On grant, register pmem_addr (and pmem_wdata for a write), set pmem_read or pmem_write, and update last_grant.
  - Go to SERVE_I or SERVE_D. A request seen at edge k drives the pmem request during cycle k+1.
- d_read and d_write both high is a protocol violation. Write wins and only pmem_write is asserted.
- SERVE_x:
  - pmem_read/pmem_write, pmem_addr and pmem_wdata are held constant until pmem_resp.
  - Requester input changes are ignored, because values were latched at grant.
  - On pmem_resp: drop pmem_read/pmem_write at the next edge, capture pmem_rdata into x_rdata (writes leave x_rdata unchanged), and go to RESP.
- RESP:
  - x_resp=1 for exactly one cycle; the other resp stays 0. Then go to IDLE.
  - Requester deasserts on the cycle after resp, so IDLE never re-grants a completed request.
- Minimum latency: request edge k; pmem_resp at cycle k+1 gives x_resp at cycle k+2, i.e. 2 cycles plus memory latency.
- Back-to-back: the next grant is evaluated in the IDLE cycle after RESP. There is a minimum one idle cycle between pmem requests.
- pmem_resp in IDLE or RESP is ignored.
- i_resp and d_resp are never high in the same cycle. pmem_read and pmem_write are never high together.
- x_rdata holds its last value between responses.

Test Plan:
- Reset during SERVE_D with pmem_write=1, then rst for 1 cycle -> next cycle pmem_write=0, d_resp=0, state IDLE. A pmem_resp after reset produces no resp.
- Lone icache read: i_addr=0x00000060, memory returns 0xA5...A5 after 3 cycles -> pmem_read=1 with pmem_addr=0x60 from cycle 1. i_resp is pulsed once with i_rdata=0xA5...A5; d_resp stays 0.
- Simultaneous i_read (0x100) and d_read (0x200) right after reset -> dcache served first (pmem_addr=0x200), then icache (0x100) after one idle cycle. Each resp is pulsed exactly once.
- Continuous contention: icache and dcache re-request immediately after each resp for 6 transactions -> grants alternate D,I,D,I,D,I; neither is starved.
- dcache writeback: d_write, d_addr=0x340, d_wdata=0xDEADBEEF... -> pmem_write=1 with matching addr/wdata, held until pmem_resp. d_resp pulses and d_rdata is unchanged. Changing d_wdata mid-transaction does not alter pmem_wdata.
- d_read and d_write both asserted -> only pmem_write asserted. A pmem_resp injected in IDLE -> no resp generated.
